// File: rtl/mnist_pkg.sv
// Shared types for the MNIST feature pipeline: the feature word, the source FSM states and the checksum width.
package mnist_pkg;

    localparam int FEATURE_WIDTH  = 16;
    localparam int CHECKSUM_WIDTH = 32;

    typedef logic signed [FEATURE_WIDTH-1:0] feature_type;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_SEND,
        SRC_DONE
    } src_state_type;

endpackage

// File: rtl/feature_if.sv
// Valid/ready feature stream. The transmitter holds valid and features stable until it samples ready high at a posedge.
interface feature_if #(
    parameter int NUM_FEATURES = 1
);

    logic                  valid;
    logic                  ready;
    mnist_pkg::feature_type features [NUM_FEATURES];

    modport tx (output valid, output features, input ready);
    modport rx (input valid, input features, output ready);

endinterface

// File: rtl/feature_frame_ram.sv
// Frame buffer: one synchronous write port, one combinational read port, contents survive reset.
module feature_frame_ram
    import mnist_pkg::*;
#(
    parameter int DEPTH      = 196,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  feature_type           wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output feature_type           rd_data
);

    feature_type r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/feature_stream_source.sv
// Streams one stored frame, one feature per handshake, then pulses done.
// Optional running checksum is built only when FEATURE_SOURCE_CHECKSUM_EN is defined.
module feature_stream_source
    import mnist_pkg::*;
#(
    parameter int VECTOR_LENGTH = 196,
    parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  feature_type               wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       beat_count,
    output logic [CHECKSUM_WIDTH-1:0] checksum,
    feature_if.tx                     features_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(VECTOR_LENGTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH      = (ADDR_WIDTH + 1)'(VECTOR_LENGTH);

    src_state_type         r_state;
    src_state_type         w_next_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH:0]   r_beat_count;
    logic                  w_launch;
    logic                  w_handshake;
    logic                  w_wr_accept;
    feature_type           w_rd_data;

    assign w_launch    = (r_state == SRC_IDLE) && start;
    assign w_handshake = (r_state == SRC_SEND) && features_out.ready;
    // The extra address bit keeps the range check correct when VECTOR_LENGTH is a power of two.
    assign w_wr_accept = wr_en && (r_state == SRC_IDLE) && ({1'b0, wr_addr} < DEPTH);

    feature_frame_ram #(
        .DEPTH      (VECTOR_LENGTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_frame_ram (
        .clock   (clock),
        .wr_en   (w_wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_index),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SRC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SRC_IDLE: if (start) w_next_state = SRC_SEND;
            SRC_SEND: if (w_handshake && (r_index == LAST_INDEX)) w_next_state = SRC_DONE;
            SRC_DONE: w_next_state = SRC_IDLE;
            default:  w_next_state = SRC_IDLE;
        endcase
    end

    // The index parks on the last entry after the final beat; only a new start rewinds it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index      <= '0;
            r_beat_count <= '0;
        end else if (w_launch) begin
            r_index      <= '0;
            r_beat_count <= '0;
        end else if (w_handshake) begin
            r_beat_count <= r_beat_count + (ADDR_WIDTH + 1)'(1);
            if (r_index != LAST_INDEX) begin
                r_index <= r_index + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef FEATURE_SOURCE_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] r_checksum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_launch) begin
            r_checksum <= '0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + CHECKSUM_WIDTH'(w_rd_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign features_out.valid       = (r_state == SRC_SEND);
    assign features_out.features[0] = (r_state == SRC_SEND) ? w_rd_data : '0;
    assign busy                     = (r_state == SRC_SEND) || (r_state == SRC_DONE);
    assign done                     = (r_state == SRC_DONE);
    assign beat_count               = r_beat_count;

endmodule

// File: tb/tb_feature_stream_source.sv
// Directed bench for feature_stream_source; checksum expectations follow FEATURE_SOURCE_CHECKSUM_EN.
module tb_feature_stream_source;
    import mnist_pkg::*;

    localparam int VL = 196;
    localparam int AW = $clog2(VL);

    logic                clock = 1'b0;
    logic                reset_n;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    feature_type         wr_data;
    logic                start;
    logic                busy;
    logic                done;
    logic [AW:0]         beat_count;
    logic [31:0]         checksum;

    feature_if #(.NUM_FEATURES(1)) feat_if ();

    int          tests_run    = 0;
    int          tests_failed = 0;
    feature_type model [VL];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          done_cnt;
    int          done_cyc;
    int          stable_err;
    bit          ab;

    feature_stream_source #(
        .VECTOR_LENGTH (VL),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .beat_count   (beat_count),
        .checksum     (checksum),
        .features_out (feat_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1; 2: start pulses while busy; 3: writes while busy
    task automatic run_frame(input int mode, input int rst_at, input bit same_wr,
                             input string tag, output bit aborted);
        logic [15:0] held;
        bit          hold_pending;
        int          k;
        int          mism;
        int          exp_sum;
        logic [31:0] exp_cs;
        aborted = 1'b0;
        if (same_wr) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_data  = 16'sd55;
            model[0] = 16'sd55;
        end
        exp_q.delete();
        exp_sum = 0;
        for (int i = 0; i < VL; i++) begin
            exp_q.push_back(model[i]);
            exp_sum += int'(model[i]);
        end
        got_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        stable_err   = 0;
        hold_pending = 1'b0;
        held         = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_start_beat_count"}, 32'(beat_count), 0);
        check({tag, "_start_valid"}, 32'(feat_if.valid), 1);
        k = 0;
        while (k < 1200 && (done_cyc < 0 || k < done_cyc + 3)) begin
            k++;
            if (rst_at > 0 && got_q.size() == rst_at) begin
                reset_n = 1'b0;
                #1;
                check({tag, "_valid_async"}, 32'(feat_if.valid), 0);
                check({tag, "_busy_async"}, 32'(busy), 0);
                check({tag, "_feature_async"}, 32'(feat_if.features[0]), 0);
                aborted = 1'b1;
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (mode == 1) feat_if.ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
            else           feat_if.ready = 1'b1;
            start   = (mode == 2) && busy && (k % 3 == 0);
            wr_en   = (mode == 3) && busy;
            wr_addr = AW'(k % VL);
            wr_data = 16'sh7EEF;
            if (feat_if.valid) begin
                if (hold_pending && feat_if.features[0] !== held) stable_err++;
                held         = feat_if.features[0];
                hold_pending = !feat_if.ready;
                if (feat_if.ready) got_q.push_back(feat_if.features[0]);
            end else begin
                hold_pending = 1'b0;
            end
            tick();
        end
        start         = 1'b0;
        wr_en         = 1'b0;
        feat_if.ready = 1'b1;
        if (aborted) return;
        check({tag, "_beats"}, 32'(got_q.size()), VL);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < VL; i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
        end
        check({tag, "_data_mismatches"}, 32'(mism), 0);
        check({tag, "_done_count"}, 32'(done_cnt), 1);
        check({tag, "_done_cycle"}, 32'(done_cyc), (mode == 1) ? 2 * VL + 1 : VL + 1);
        check({tag, "_stable_errors"}, 32'(stable_err), 0);
        check({tag, "_beat_count"}, 32'(beat_count), VL);
        check({tag, "_busy_after"}, 32'(busy), 0);
`ifdef FEATURE_SOURCE_CHECKSUM_EN
        exp_cs = 32'(exp_sum);
`else
        exp_cs = 32'd0;
`endif
        check({tag, "_checksum"}, checksum, exp_cs);
    endtask

    initial begin
        reset_n       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        start         = 1'b0;
        feat_if.ready = 1'b0;
        #12;
        check("rst_valid", 32'(feat_if.valid), 0);
        check("rst_feature", 32'(feat_if.features[0]), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_beat_count", 32'(beat_count), 0);
        check("rst_checksum", checksum, 0);
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < VL; i++) begin
            wr_en    = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = feature_type'(i + 1);
            model[i] = feature_type'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        tick();

        run_frame(0, 0, 1'b0, "basic", ab);
        run_frame(1, 0, 1'b0, "backpressure", ab);
        run_frame(3, 0, 1'b0, "busy_writes", ab);

        wr_en   = 1'b1;
        wr_addr = AW'(200);
        wr_data = 16'sd999;
        tick();
        wr_en = 1'b0;
        tick();
        run_frame(0, 0, 1'b0, "repeat", ab);
        run_frame(2, 0, 1'b0, "start_pulses", ab);

        run_frame(0, 50, 1'b0, "midreset", ab);
        check("midreset_aborted", 32'(ab), 1);
        done_cnt = 0;
        repeat (3) begin
            if (done) done_cnt++;
            tick();
        end
        check("midreset_no_done", 32'(done_cnt), 0);
        check("midreset_beat_count", 32'(beat_count), 0);
        reset_n = 1'b1;
        tick();
        if (done) done_cnt++;
        check("midreset_no_done_after", 32'(done_cnt), 0);
        run_frame(0, 0, 1'b0, "restart", ab);

        run_frame(0, 0, 1'b1, "same_cycle", ab);
        check("same_cycle_first_beat", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
